// File: rtl/lane_spawn_scheduler.sv
// Round-robin lane arbiter that turns the shared LFSR byte into a spawn offer
// (lane, speed, direction) and gives each lane its own post-spawn cooldown.
module lane_spawn_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2,
    parameter int MIN_GAP   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 enable,
    input  logic [7:0]           rnd,
    input  logic [NUM_LANES-1:0] lane_busy,
    input  logic                 spawn_ack,
    output logic                 spawn_valid,
    output logic [LANE_W-1:0]    spawn_lane,
    output logic [1:0]           spawn_speed,
    output logic                 spawn_dir,
    output logic [7:0]           spawn_total
);

    typedef enum logic [1:0] {IDLE, ARB, OFFER} state_t;

    state_t               state;
    logic [7:0]           cooldown [NUM_LANES];
    logic [LANE_W-1:0]    last_grant;
    logic [4:0]           cd_add;
    logic [NUM_LANES-1:0] eligible;
    logic                 found;
    logic [LANE_W-1:0]    pick;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LANES; i++)
            eligible[i] = (cooldown[i] == 8'd0) && !lane_busy[i] && enable;
    end

    // Search starts one past the previous winner and wraps, so the first hit is the fairest.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!found && (i == (int'(last_grant) + k) % NUM_LANES) && eligible[i]) begin
                    found = 1'b1;
                    pick  = LANE_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= LANE_W'(NUM_LANES - 1);
            cd_add      <= '0;
            spawn_valid <= 1'b0;
            spawn_lane  <= '0;
            spawn_speed <= 2'd0;
            spawn_dir   <= 1'b0;
            spawn_total <= 8'd0;
            for (int i = 0; i < NUM_LANES; i++)
                cooldown[i] <= 8'd0;
        end else begin
            // A fresh load on acceptance overrides the tick decrement for that lane.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (state == OFFER && spawn_ack && spawn_lane == LANE_W'(i))
                    cooldown[i] <= 8'(MIN_GAP) + {3'b000, cd_add};
                else if (tick && cooldown[i] != 8'd0)
                    cooldown[i] <= cooldown[i] - 8'd1;
            end

            case (state)
                IDLE: begin
                    if (tick && enable)
                        state <= ARB;
                end
                ARB: begin
                    if (found) begin
                        spawn_valid <= 1'b1;
                        spawn_lane  <= pick;
                        spawn_speed <= (rnd[1:0] == 2'b00) ? 2'b01 : rnd[1:0];
                        spawn_dir   <= rnd[2];
                        cd_add      <= rnd[7:3];
                        state       <= OFFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OFFER: begin
                    if (spawn_ack) begin
                        spawn_valid <= 1'b0;
                        last_grant  <= spawn_lane;
                        spawn_total <= spawn_total + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// Bench for lane_spawn_scheduler: fixed vectors, hand-built corner sequences,
// then random traffic compared against a queue-free behavioural model.
module tb_lane_spawn_scheduler;

    localparam int NL      = 4;
    localparam int MIN_GAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] rnd = 8'd0;
    logic [3:0] lane_busy = 4'd0;
    logic       spawn_ack = 1'b0;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic [1:0] spawn_speed;
    logic       spawn_dir;
    logic [7:0] spawn_total;

    always #5 clk = ~clk;

    lane_spawn_scheduler #(.NUM_LANES(NL), .LANE_W(2), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable), .rnd(rnd),
        .lane_busy(lane_busy), .spawn_ack(spawn_ack), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_speed(spawn_speed), .spawn_dir(spawn_dir),
        .spawn_total(spawn_total)
    );

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model: spawn rules stated directly in integers.
    int m_cd [NL];
    int m_last;
    bit m_arb_pending;
    bit m_offer;
    int m_lane, m_speed, m_dir, m_add, m_total;

    task automatic modelStep();
        int nxt [NL];
        int r;
        if (rst) begin
            for (int i = 0; i < NL; i++) m_cd[i] = 0;
            m_last = NL - 1;
            m_arb_pending = 0;
            m_offer = 0;
            m_lane = 0; m_speed = 0; m_dir = 0; m_add = 0; m_total = 0;
        end else begin
            for (int i = 0; i < NL; i++)
                nxt[i] = (tick && m_cd[i] > 0) ? m_cd[i] - 1 : m_cd[i];
            if (m_offer) begin
                if (spawn_ack) begin
                    nxt[m_lane] = MIN_GAP + m_add;
                    m_last  = m_lane;
                    m_total = (m_total + 1) % 256;
                    m_offer = 0;
                end
            end else if (m_arb_pending) begin
                m_arb_pending = 0;
                r = int'(rnd);
                for (int k = 1; k <= NL; k++) begin
                    int l;
                    l = (m_last + k) % NL;
                    if (m_cd[l] == 0 && !lane_busy[l[1:0]] && enable) begin
                        m_lane  = l;
                        m_speed = (r % 4 == 0) ? 1 : r % 4;
                        m_dir   = (r / 4) % 2;
                        m_add   = r / 8;
                        m_offer = 1;
                        break;
                    end
                end
            end else if (tick && enable) begin
                m_arb_pending = 1;
            end
            for (int i = 0; i < NL; i++) m_cd[i] = nxt[i];
        end
    endtask

    task automatic applyStimulus(input bit r, input bit t, input bit e,
                                 input logic [7:0] rn, input logic [3:0] b, input bit a);
        @(negedge clk);
        rst = r; tick = t; enable = e; rnd = rn; lane_busy = b; spawn_ack = a;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic expectOut(input string name, input int v, input int lane,
                             input int sp, input int dir, input int tot);
        total_checks++;
        if (int'(spawn_valid) != v || int'(spawn_lane) != lane || int'(spawn_speed) != sp ||
            int'(spawn_dir) != dir || int'(spawn_total) != tot) begin
            bad_checks++;
            $display("[TB] FAIL %s: got v=%0d lane=%0d sp=%0d dir=%0d tot=%0d, want v=%0d lane=%0d sp=%0d dir=%0d tot=%0d",
                     name, spawn_valid, spawn_lane, spawn_speed, spawn_dir, spawn_total,
                     v, lane, sp, dir, tot);
        end
    endtask

    task automatic checkOutput(input string name);
        expectOut(name, int'(m_offer), m_lane, m_speed, m_dir, m_total);
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total_checks++;
        if (got != want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    typedef struct {
        bit         r, t, e;
        logic [7:0] rn;
        logic [3:0] b;
        bit         a;
        int         v, lane, sp, dir, tot;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int ticks_seen;
        int got_lane;
        int got_valid;

        // Single spawn, then the slicing extremes 8'hFF and 8'h00 on the next two lanes.
        vecs[0] = '{1, 0, 1, 8'h0D, 4'h0, 0,  0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 1, 8'h0D, 4'h0, 0,  0, 0, 0, 0, 0};
        vecs[2] = '{0, 0, 1, 8'h0D, 4'h0, 0,  1, 0, 1, 1, 0};
        vecs[3] = '{0, 0, 1, 8'h0D, 4'h0, 1,  0, 0, 1, 1, 1};
        vecs[4] = '{0, 1, 1, 8'hFF, 4'h0, 0,  0, 0, 1, 1, 1};
        vecs[5] = '{0, 0, 1, 8'hFF, 4'h0, 0,  1, 1, 3, 1, 1};
        vecs[6] = '{0, 0, 1, 8'hFF, 4'h0, 1,  0, 1, 3, 1, 2};
        vecs[7] = '{0, 1, 1, 8'h00, 4'h0, 0,  0, 1, 3, 1, 2};
        vecs[8] = '{0, 0, 1, 8'h00, 4'h0, 0,  1, 2, 1, 0, 2};
        vecs[9] = '{0, 0, 1, 8'h00, 4'h0, 1,  0, 2, 1, 0, 3};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].r, vecs[i].t, vecs[i].e, vecs[i].rn, vecs[i].b, vecs[i].a);
            expectOut($sformatf("vec%0d", i), vecs[i].v, vecs[i].lane, vecs[i].sp,
                      vecs[i].dir, vecs[i].tot);
        end

        // Lane 0 loaded with 16+1 must refuse 16 ticks and accept on the 17th.
        applyStimulus(1, 0, 1, 8'h0D, 4'h0, 0);
        applyStimulus(0, 1, 1, 8'h0D, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h0D, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h0D, 4'h0, 1);
        ticks_seen = -1;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(0, 1, 1, 8'h00, 4'b1110, 0);
            applyStimulus(0, 0, 1, 8'h00, 4'b1110, 0);
            if (spawn_valid) begin
                ticks_seen = k;
                break;
            end
            applyStimulus(0, 0, 1, 8'h00, 4'b1110, 0);
        end
        checkValue("cooldown17_ticks", ticks_seen, 17);
        checkOutput("cooldown17_offer");
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);

        // Round robin with immediate acks; the fifth tick finds every lane cooling.
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 0);
        for (int t = 0; t < 5; t++) begin
            applyStimulus(0, 1, 1, 8'h00, 4'h0, 0);
            applyStimulus(0, 0, 1, 8'h00, 4'h0, 0);
            got_valid = int'(spawn_valid);
            got_lane  = int'(spawn_lane);
            applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);
            applyStimulus(0, 0, 1, 8'h00, 4'h0, 0);
            checkValue($sformatf("rr_valid%0d", t), got_valid, (t < 4) ? 1 : 0);
            if (t < 4) checkValue($sformatf("rr_lane%0d", t), got_lane, t);
        end
        checkValue("rr_total", int'(spawn_total), 4);

        // Backpressure: offer must hold through 10 unacked cycles and 3 ticks.
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 0);
        applyStimulus(0, 1, 1, 8'h5A, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h5A, 4'h0, 0);
        expectOut("bp_offer", 1, 0, 2, 0, 0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, (c % 3 == 1), (c % 2 == 0), 8'($urandom), 4'($urandom), 0);
            expectOut($sformatf("bp_hold%0d", c), 1, 0, 2, 0, 0);
        end
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);
        expectOut("bp_ack", 0, 0, 2, 0, 1);

        // Busy masking and skipping of cooling lanes.
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 0);
        applyStimulus(0, 1, 1, 8'h00, 4'b0111, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'b0111, 0);
        expectOut("mask_lane3", 1, 3, 1, 0, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);
        applyStimulus(0, 1, 1, 8'h00, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 0);
        expectOut("mask_lane0", 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);
        applyStimulus(0, 1, 1, 8'h00, 4'b0010, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'b0010, 0);
        expectOut("mask_lane2", 1, 2, 1, 0, 2);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);
        applyStimulus(0, 1, 1, 8'h00, 4'b1111, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'b1111, 0);
        checkValue("allbusy_none_a", int'(spawn_valid), 0);
        applyStimulus(0, 0, 1, 8'h00, 4'b1111, 0);
        checkValue("allbusy_none_b", int'(spawn_valid), 0);
        applyStimulus(0, 1, 1, 8'h00, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 0);
        expectOut("after_idle_lane1", 1, 1, 1, 0, 3);
        applyStimulus(0, 0, 1, 8'h00, 4'h0, 1);

        // Reset in the middle of an offer.
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 0);
        applyStimulus(0, 1, 1, 8'h07, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h07, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h07, 4'h0, 1);
        applyStimulus(0, 1, 1, 8'h07, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h07, 4'h0, 0);
        expectOut("pre_reset_offer", 1, 1, 3, 1, 1);
        applyStimulus(1, 0, 1, 8'h07, 4'h0, 0);
        expectOut("reset_mid_offer", 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 8'h02, 4'h0, 0);
        applyStimulus(0, 0, 1, 8'h02, 4'h0, 0);
        expectOut("post_reset_lane0", 1, 0, 2, 0, 0);

        // Random traffic against the model.
        applyStimulus(1, 0, 1, 8'h00, 4'h0, 0);
        checkOutput("rand_reset");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) != 0),
                          8'($urandom),
                          4'($urandom),
                          ($urandom_range(0, 1) == 1));
            checkOutput($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
